// File: rtl/mux_arb_n_pkg.sv
// Shared helpers for mux_arb_n: ceiling log2 and the channel-select width.
package mux_arb_n_pkg;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   // A select index is never narrower than one bit, even for a single channel.
   function automatic int sel_w(input int channels);
      return (clog2(channels) < 1) ? 1 : clog2(channels);
   endfunction

endpackage

// File: rtl/mux_arb_n_rr_arbiter.sv
// Round-robin priority search from ptr upward, modulo N; purely combinational.
// Produces a one-hot grant, its binary index and an any-request flag.
module rr_arbiter #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] grant,
   output logic [W-1:0] grant_idx,
   output logic         any
);

   int idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      idx       = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!any && req[idx]) begin
            any        = 1'b1;
            grant_idx  = W'(idx);
            grant[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_arb_n.sv
// N-to-1 arbitrated mux into a single output register; latency 1 cycle, one word per cycle.
// Input acceptance is gated by load_en, so a stalled output holds its word and grants nothing.
module mux_arb_n
   import mux_arb_n_pkg::*;
#(
   parameter int Width      = 32,
   parameter int Channels   = 4,
   parameter int RoundRobin = 1,
   localparam int SelW      = sel_w(Channels)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [Channels*Width-1:0] in_data,
   input  logic [Channels-1:0]       in_valid,
   output logic [Channels-1:0]       in_ready,
   input  logic [SelW-1:0]           sel,
   output logic [Width-1:0]          out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [SelW-1:0]           out_ch
);

   logic [Width-1:0]    out_data_q, out_data_d;
   logic                out_valid_q, out_valid_d;
   logic [SelW-1:0]     out_ch_q, out_ch_d;
   logic [SelW-1:0]     ptr_q, ptr_d;

   logic                load_en;
   logic                xfer_in;
   logic                gnt_any;
   logic [SelW-1:0]     gnt_idx;
   logic [Channels-1:0] gnt_vec;
   logic [Channels-1:0] rr_grant;
   logic [SelW-1:0]     rr_idx;
   logic                rr_any;
   logic [Width-1:0]    sel_dat;

   rr_arbiter #(
      .N (Channels),
      .W (SelW)
   ) u_rr_arbiter (
      .req       (in_valid),
      .ptr       (ptr_q),
      .grant     (rr_grant),
      .grant_idx (rr_idx),
      .any       (rr_any)
   );

   // Grant selection: never looks at in_data, so in_ready has no data path.
   always_comb begin
      gnt_idx = '0;
      gnt_vec = '0;
      gnt_any = 1'b0;
      if (RoundRobin != 0) begin
         gnt_idx = rr_idx;
         gnt_vec = rr_grant;
         gnt_any = rr_any;
      end else begin
         gnt_idx = sel;
         if (int'(sel) < Channels) begin
            gnt_any      = in_valid[sel];
            gnt_vec[sel] = in_valid[sel];
         end
      end
   end

   always_comb begin
      load_en  = !out_valid_q || out_ready;
      xfer_in  = rst_n && load_en && gnt_any;
      in_ready = xfer_in ? gnt_vec : '0;
      sel_dat  = in_data[int'(gnt_idx)*Width +: Width];
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q && !out_ready;
      if (xfer_in) begin
         out_data_d  = sel_dat;
         out_ch_d    = gnt_idx;
         out_valid_d = 1'b1;
         ptr_d       = (int'(gnt_idx) == Channels - 1) ? '0 : gnt_idx + SelW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         ptr_q       <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_ch_q    <= out_ch_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n: round-robin and fixed-select instances,
// expected output words queued by stimulus and checked by per-instance monitors.
module tb_mux_arb_n;

   logic        clk = 1'b0;
   logic        rst_n;

   logic [127:0] in_data;
   logic [3:0]   in_valid;
   logic [3:0]   in_ready;
   logic [1:0]   sel;
   logic [31:0]  out_data;
   logic         out_valid;
   logic         out_ready;
   logic [1:0]   out_ch;

   logic [127:0] f_in_data;
   logic [3:0]   f_in_valid;
   logic [3:0]   f_in_ready;
   logic [1:0]   f_sel;
   logic [31:0]  f_out_data;
   logic         f_out_valid;
   logic         f_out_ready;
   logic [1:0]   f_out_ch;

   int n_cmp = 0;
   int n_bad = 0;

   logic [33:0] q[$];
   logic [33:0] fq[$];

   always #5 clk = ~clk;

   mux_arb_n #(.Width(32), .Channels(4), .RoundRobin(1)) u_rr (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .sel(sel), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_ch(out_ch)
   );

   mux_arb_n #(.Width(32), .Channels(4), .RoundRobin(0)) u_fix (
      .clk(clk), .rst_n(rst_n), .in_data(f_in_data), .in_valid(f_in_valid),
      .in_ready(f_in_ready), .sel(f_sel), .out_data(f_out_data), .out_valid(f_out_valid),
      .out_ready(f_out_ready), .out_ch(f_out_ch)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Output monitors: every completed output transfer must match the queue head.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("rr_unexpected_word", 64'({out_ch, out_data}), 64'h0);
            if ({out_ch, out_data} == 34'h0) begin
               n_bad++;
               $display("FAIL rr_unexpected_word: got %0h expected none", {out_ch, out_data});
            end
         end else begin
            chk("rr_out_word", 64'({out_ch, out_data}), 64'(q.pop_front()));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && f_out_valid && f_out_ready) begin
         if (fq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL fix_unexpected_word: got %0h expected none", {f_out_ch, f_out_data});
         end else begin
            chk("fix_out_word", 64'({f_out_ch, f_out_data}), 64'(fq.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      in_valid    = 4'hF;
      out_ready   = 1'b1;
      sel         = 2'd0;
      for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hA0 + 32'(i);
      f_in_valid  = 4'h0;
      f_out_ready = 1'b1;
      f_sel       = 2'd0;
      for (int i = 0; i < 4; i++) f_in_data[i*32 +: 32] = 32'h1111_1111 * 32'(i + 1);
      f_in_data[2*32 +: 32] = 32'hDEADBEEF;

      // Reset held with all channels requesting
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'h0);
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_out_data", 64'(out_data), 64'h0);
      chk("rst_out_ch", 64'(out_ch), 64'h0);
      tick;
      in_valid = 4'h0;
      rst_n    = 1'b1;
      tick;
      @(negedge clk);
      chk("post_rst_out_valid", 64'(out_valid), 64'h0);
      chk("post_rst_out_data", 64'(out_data), 64'h0);

      // Round-robin fairness, one word per cycle
      tick;
      in_valid = 4'hF;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("rr_in_ready", 64'(in_ready), 64'(4'b0001 << (k % 4)));
         if (k > 0) chk("rr_throughput_valid", 64'(out_valid), 64'h1);
         q.push_back({2'(k % 4), 32'hA0 + 32'(k % 4)});
         tick;
      end
      in_valid = 4'h0;
      tick;

      // Backpressure: ptr is 1 here
      in_valid  = 4'hF;
      out_ready = 1'b0;
      @(negedge clk);
      chk("bp_first_grant", 64'(in_ready), 64'h2);
      q.push_back({2'd1, 32'hA1});
      tick;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_out_valid", 64'(out_valid), 64'h1);
         chk("bp_out_data", 64'(out_data), 64'hA1);
         chk("bp_out_ch", 64'(out_ch), 64'h1);
         chk("bp_in_ready", 64'(in_ready), 64'h0);
         tick;
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_grant", 64'(in_ready), 64'h4);
      q.push_back({2'd2, 32'hA2});
      tick;
      in_valid = 4'h0;
      tick;

      // Sparse requests and pointer wrap: ptr is 3 here
      in_valid = 4'b0001;
      @(negedge clk);
      chk("sparse_to_ptr1", 64'(in_ready), 64'h1);
      q.push_back({2'd0, 32'hA0});
      tick;
      in_valid = 4'b1001;
      @(negedge clk);
      chk("sparse_grant3", 64'(in_ready), 64'h8);
      q.push_back({2'd3, 32'hA3});
      tick;
      @(negedge clk);
      chk("sparse_wrap_grant0", 64'(in_ready), 64'h1);
      q.push_back({2'd0, 32'hA0});
      tick;
      in_valid = 4'h0;
      tick;

      // Mid-operation reset discards the held word; ptr is 1 here
      in_valid  = 4'b0010;
      out_ready = 1'b0;
      @(negedge clk);
      chk("mrst_grant", 64'(in_ready), 64'h2);
      tick;
      in_valid = 4'h0;
      rst_n    = 1'b0;
      @(negedge clk);
      chk("mrst_held_valid", 64'(out_valid), 64'h1);
      chk("mrst_in_ready", 64'(in_ready), 64'h0);
      tick;
      @(negedge clk);
      chk("mrst_out_valid", 64'(out_valid), 64'h0);
      chk("mrst_out_data", 64'(out_data), 64'h0);
      tick;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      tick;
      in_valid = 4'b1001;
      @(negedge clk);
      chk("mrst_ptr_reset", 64'(in_ready), 64'h1);
      q.push_back({2'd0, 32'hA0});
      tick;
      in_valid = 4'h0;
      tick;

      // Fixed-select instance
      f_sel      = 2'd2;
      f_in_valid = 4'b1011;
      @(negedge clk);
      chk("fix_no_grant", 64'(f_in_ready), 64'h0);
      tick;
      @(negedge clk);
      chk("fix_no_grant_valid", 64'(f_out_valid), 64'h0);
      tick;
      f_in_valid = 4'b0100;
      @(negedge clk);
      chk("fix_grant2", 64'(f_in_ready), 64'h4);
      fq.push_back({2'd2, 32'hDEADBEEF});
      tick;
      f_sel      = 2'd0;
      f_in_valid = 4'b0001;
      @(negedge clk);
      chk("fix_out_data", 64'(f_out_data), 64'hDEADBEEF);
      chk("fix_out_ch", 64'(f_out_ch), 64'h2);
      chk("fix_sel_change_grant", 64'(f_in_ready), 64'h1);
      fq.push_back({2'd0, 32'h1111_1111});
      tick;
      f_in_valid = 4'h0;

      for (int i = 0; i < 20 && (q.size() != 0 || fq.size() != 0); i++) tick;
      chk("rr_queue_drained", 64'(q.size()), 64'h0);
      chk("fix_queue_drained", 64'(fq.size()), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mux_arb_n.md
MUX_ARB_N -- requirements
Module: mux_arb_n

Interface
REQ-001 Parameter Width, default 32, data width per channel.
REQ-002 Parameter Channels, default 4, input channel count, legal range 2..16.
REQ-003 Parameter RoundRobin, default 1, 1 = round-robin arbitration, 0 = fixed select via sel.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 in_data  input  Channels*Width  packed channel data; channel i occupies bits [i*Width +: Width].
REQ-007 in_valid  input  Channels  per-channel data-valid.
REQ-008 in_ready  output  Channels  per-channel accept; one-hot or zero.
REQ-009 sel  input  SelW (= clog2(Channels))  selected channel when RoundRobin = 0; ignored otherwise.
REQ-010 out_data  output  Width  registered selected data.
REQ-011 out_valid  output  1  out_data holds an unconsumed word.
REQ-012 out_ready  input  1  downstream accept.
REQ-013 out_ch  output  SelW  channel index that produced out_data.

Function
REQ-014 A transfer on channel i SHALL occur when in_valid[i] && in_ready[i] in the same cycle; output transfer when out_valid && out_ready.
REQ-015 The output stage SHALL be a single register: load_en = !out_valid || out_ready.
REQ-016 in_ready SHALL be zero when load_en is 0; otherwise in_ready[g] = 1 only for the granted channel g.
REQ-017 RoundRobin = 0: g = sel; grant SHALL be issued only if in_valid[sel]; sel >= Channels SHALL grant nothing.
REQ-018 RoundRobin = 1: g = first channel with in_valid set, searching ptr, ptr+1, ... modulo Channels.
REQ-019 Pointer ptr SHALL update to (g+1) mod Channels only on a completed input transfer; wrap from Channels-1 to 0.
REQ-020 On input transfer, out_data <= channel g data, out_ch <= g, out_valid <= 1 at next edge (latency 1 cycle).
REQ-021 On output transfer with no concurrent input transfer, out_valid <= 0; out_data and out_ch SHALL hold.
REQ-022 Simultaneous output and input transfer SHALL load new data with out_valid remaining 1 (full throughput, one word per cycle).
REQ-023 While out_valid && !out_ready, out_data, out_ch, out_valid and ptr SHALL remain stable.
REQ-024 No in_valid set while load_en: no grant, ptr unchanged.
REQ-025 in_ready SHALL depend combinationally on in_valid, sel, ptr, out_valid, out_ready only; no combinational path from in_data.
REQ-026 Mode change of sel between cycles SHALL take effect in the cycle it is presented; no in-flight word is dropped.

Reset
REQ-027 rst_n low at a rising edge SHALL set out_valid = 0, out_data = 0, out_ch = 0, ptr = 0.
REQ-028 While rst_n is low, in_ready SHALL be all-zero.
REQ-029 Reset mid-transfer SHALL discard the held word; no transfer is completed in the reset cycle.

Structure
REQ-030 Shared package SHALL hold clog2 helper and SelW derivation; no other typedefs.
REQ-031 Round-robin priority search SHALL be a sub-module rr_arbiter (inputs req, ptr; outputs grant one-hot, grant index, any).
REQ-032 Data selection SHALL use the grant index into the packed bus; no per-channel registers besides output stage.

Verification
REQ-033 Reset: hold rst_n=0 with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0 after release edge.
REQ-034 Round-robin fairness: RoundRobin=1, in_valid=4'b1111 constant, out_ready=1, data ch i = 32'hA0+i -> out_ch sequence 0,1,2,3,0 with one word per cycle.
REQ-035 Backpressure: out_ready=0 for 3 cycles after out_valid -> out_data, out_ch stable, in_ready=0; on out_ready=1 next word loads same cycle.
REQ-036 Sparse requests: in_valid=4'b1001, ptr=1 -> grant channel 3, then ptr=0 -> grant 0; wrap verified.
REQ-037 Fixed mode: RoundRobin=0, sel=2, in_valid[2]=0 -> no grant; in_valid[2]=1, in_data ch2=32'hDEADBEEF -> out_data=32'hDEADBEEF, out_ch=2 one cycle later.
REQ-038 Mid-operation reset: rst_n low while out_valid=1, out_ready=0 -> out_valid=0 next edge, word not emitted after release.
